fwd_scoreboard: RTL and testbench

- Parametrised forwarding/hazard unit for the pipelined MIPS core; successor to the fixed two-stage, two-operand forwarding logic.
- Keeps its own shift pipeline of destination tags (one entry per post-EX stage), so the datapath no longer routes per-stage RegWrite/Rd into the unit.
- Per EX-stage source operand, selects the youngest ready producer. Raises a load-use stall when the youngest producer is not ready yet, and inserts the bubble itself.

---
 rtl/fwd_scoreboard_pkg.sv | 20 ++
 rtl/fwd_match_slice.sv | 45 ++++
 rtl/fwd_scoreboard.sv | 106 ++++++++++
 tb/tb_fwd_scoreboard.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// rtl/fwd_scoreboard_pkg.sv - shared constants, tag-entry record and select-width helper
package fwd_scoreboard_pkg;

  localparam int FWD_SEL_RF = 0;

  // Tag entries carry rd at a fixed maximum width; narrower register files zero-extend.
  localparam int TAG_RD_MAX_W = 8;

  typedef struct packed {
    logic                    valid;
    logic                    regwrite;
    logic                    load;
    logic [TAG_RD_MAX_W-1:0] rd;
  } tagEntry_t;

  function automatic int minSelW(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_match_slice.sv
// rtl/fwd_match_slice.sv - per-operand youngest-producer scan over the tag pipeline
module fwd_match_slice
  import fwd_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = 2
) (
  input  tagEntry_t [DEPTH-1:0]      entries,
  input  logic      [REG_ADDR_W-1:0] srcAddr,
  input  logic                       srcUsed,
  output logic      [SEL_W-1:0]      sel,
  output logic                       notReady
);

  logic [TAG_RD_MAX_W-1:0] srcExt;
  logic [DEPTH-1:0]        cand;

  assign srcExt = TAG_RD_MAX_W'(srcAddr);

  always_comb begin
    cand = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cand[k] = srcUsed && entries[k].valid && entries[k].regwrite &&
                (entries[k].rd != '0) && (entries[k].rd == srcExt);
    end
  end

  // Only the youngest match counts; an unready youngest never falls back to an older one.
  always_comb begin
    logic found;
    found    = 1'b0;
    sel      = SEL_W'(FWD_SEL_RF);
    notReady = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && cand[k]) begin
        found = 1'b1;
        if (!entries[k].load || (k + 1) >= LOAD_STAGE) sel = SEL_W'(k + 1);
        else notReady = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - forwarding select and load-use stall unit with its own tag pipeline
// Optional stall-cycle counter output enabled by FWD_SCOREBOARD_STATS_EN.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          issue_valid_i,
  input  logic                          issue_regwrite_i,
  input  logic                          issue_load_i,
  input  logic [REG_ADDR_W-1:0]         issue_rd_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr_i,
  input  logic [NUM_SRC-1:0]            src_used_i,
  input  logic                          stall_i,
  input  logic                          flush_i,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o,
  output logic                          hazard_stall_o,
  output logic [DEPTH-1:0]              stage_valid_o
`ifdef FWD_SCOREBOARD_STATS_EN
  ,
  output logic [15:0]                   stall_cnt_o
`endif
);

  if (LOAD_STAGE < 1 || LOAD_STAGE > DEPTH) begin : gBadLoadStage
    $error("fwd_scoreboard: LOAD_STAGE must lie in 1..DEPTH");
  end
  if (SEL_W < minSelW(DEPTH)) begin : gBadSelW
    $error("fwd_scoreboard: SEL_W too narrow for DEPTH");
  end
  if (REG_ADDR_W > TAG_RD_MAX_W) begin : gBadRegW
    $error("fwd_scoreboard: REG_ADDR_W exceeds tag rd width");
  end

  tagEntry_t [DEPTH-1:0] entries;
  tagEntry_t             issueEntry;
  logic [NUM_SRC-1:0]    notReady;

  always_comb begin
    issueEntry          = '0;
    issueEntry.valid    = issue_valid_i;
    issueEntry.regwrite = issue_regwrite_i;
    issueEntry.load     = issue_load_i;
    issueEntry.rd       = TAG_RD_MAX_W'(issue_rd_i);
  end

  for (genvar j = 0; j < NUM_SRC; j++) begin : gSrc
    fwd_match_slice #(
      .REG_ADDR_W (REG_ADDR_W),
      .DEPTH      (DEPTH),
      .LOAD_STAGE (LOAD_STAGE),
      .SEL_W      (SEL_W)
    ) uSlice (
      .entries  (entries),
      .srcAddr  (src_addr_i[j*REG_ADDR_W +: REG_ADDR_W]),
      .srcUsed  (src_used_i[j]),
      .sel      (fwd_sel_o[j*SEL_W +: SEL_W]),
      .notReady (notReady[j])
    );
  end

  assign hazard_stall_o = issue_valid_i && (|notReady);

  always_comb begin
    stage_valid_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      stage_valid_o[k] = entries[k].valid && entries[k].regwrite && (entries[k].rd != '0);
    end
  end

  // Flush overrides a freeze for entry1 only; older entries still respect stall_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entries <= '0;
    end else begin
      if (flush_i || !stall_i) begin
        if (flush_i || hazard_stall_o) entries[0] <= '0;
        else                           entries[0] <= issueEntry;
      end
      if (!stall_i) begin
        for (int k = 1; k < DEPTH; k++) entries[k] <= entries[k-1];
      end
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [15:0] stallCnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stallCnt <= '0;
    end else if (hazard_stall_o && !stall_i && stallCnt != 16'hFFFF) begin
      stallCnt <= stallCnt + 16'd1;
    end
  end

  assign stall_cnt_o = stallCnt;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - scoreboard bench for fwd_scoreboard, default and DEPTH=3 builds
module tb_fwd_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       aValid, aRw, aLd, aStall, aFlush;
  logic [4:0] aRd;
  logic [9:0] aSrc;
  logic [1:0] aUsed;
  logic [3:0] aSel;
  logic       aHaz;
  logic [1:0] aSv;
  logic [15:0] aCnt;

  logic        bValid, bRw, bLd, bStall, bFlush;
  logic [4:0]  bRd;
  logic [14:0] bSrc;
  logic [2:0]  bUsed;
  logic [5:0]  bSel;
  logic        bHaz;
  logic [2:0]  bSv;
  logic [15:0] bCnt;

  fwd_scoreboard dutA (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(aValid), .issue_regwrite_i(aRw), .issue_load_i(aLd), .issue_rd_i(aRd),
    .src_addr_i(aSrc), .src_used_i(aUsed), .stall_i(aStall), .flush_i(aFlush),
    .fwd_sel_o(aSel), .hazard_stall_o(aHaz), .stage_valid_o(aSv)
`ifdef FWD_SCOREBOARD_STATS_EN
    , .stall_cnt_o(aCnt)
`endif
  );

  fwd_scoreboard #(
    .REG_ADDR_W(5), .NUM_SRC(3), .DEPTH(3), .LOAD_STAGE(3), .SEL_W(2)
  ) dutB (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(bValid), .issue_regwrite_i(bRw), .issue_load_i(bLd), .issue_rd_i(bRd),
    .src_addr_i(bSrc), .src_used_i(bUsed), .stall_i(bStall), .flush_i(bFlush),
    .fwd_sel_o(bSel), .hazard_stall_o(bHaz), .stage_valid_o(bSv)
`ifdef FWD_SCOREBOARD_STATS_EN
    , .stall_cnt_o(bCnt)
`endif
  );

`ifndef FWD_SCOREBOARD_STATS_EN
  assign aCnt = '0;
  assign bCnt = '0;
`endif

  typedef struct packed {
    logic        unit;
    logic [5:0]  sel;
    logic        stall;
    logic [2:0]  sv;
    logic        chkCnt;
    logic [15:0] cnt;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  int    vectors = 0;
  int    miscompares = 0;
  event  sampleEv;

  task automatic pushExp(input string nm, input logic unit, input logic [5:0] sel,
                         input logic stall, input logic [2:0] sv,
                         input logic chkCnt, input logic [15:0] cnt);
    exp_t e;
    e.unit = unit; e.sel = sel; e.stall = stall; e.sv = sv; e.chkCnt = chkCnt; e.cnt = cnt;
    expQ.push_back(e);
    nameQ.push_back(nm);
  endtask

  task automatic cmp(input string nm, input string field, input logic [15:0] act,
                     input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, field, act, exp);
    end
  endtask

  // Monitor: drains expectations against live outputs on each falling edge or on demand.
  initial begin
    exp_t        e;
    string       nm;
    logic [5:0]  actSel;
    logic        actStall;
    logic [2:0]  actSv;
    logic [15:0] actCnt;
    forever begin
      @(negedge clk or sampleEv);
      while (expQ.size() != 0) begin
        e  = expQ.pop_front();
        nm = nameQ.pop_front();
        if (e.unit == 1'b0) begin
          actSel = {2'b00, aSel}; actStall = aHaz; actSv = {1'b0, aSv}; actCnt = aCnt;
        end else begin
          actSel = bSel; actStall = bHaz; actSv = bSv; actCnt = bCnt;
        end
        cmp(nm, "fwd_sel", 16'(actSel), 16'(e.sel));
        cmp(nm, "hazard_stall", 16'(actStall), 16'(e.stall));
        cmp(nm, "stage_valid", 16'(actSv), 16'(e.sv));
`ifdef FWD_SCOREBOARD_STATS_EN
        if (e.chkCnt) cmp(nm, "stall_cnt", actCnt, e.cnt);
`endif
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setA(input logic v, input logic rw, input logic ld, input logic [4:0] rd,
                      input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
    aValid = v; aRw = rw; aLd = ld; aRd = rd; aSrc = {s1, s0}; aUsed = used;
  endtask

  task automatic setB(input logic v, input logic rw, input logic ld, input logic [4:0] rd,
                      input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [2:0] used);
    bValid = v; bRw = rw; bLd = ld; bRd = rd; bSrc = {s2, s1, s0}; bUsed = used;
  endtask

  task automatic expA(input string nm, input logic [5:0] sel, input logic stall,
                      input logic [2:0] sv);
    pushExp(nm, 1'b0, sel, stall, sv, 1'b0, 16'd0);
  endtask

  task automatic expB(input string nm, input logic [5:0] sel, input logic stall,
                      input logic [2:0] sv, input logic [15:0] cnt);
    pushExp(nm, 1'b1, sel, stall, sv, 1'b1, cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    setA(0, 0, 0, 0, 0, 0, 2'b00); aStall = 0; aFlush = 0;
    setB(0, 0, 0, 0, 0, 0, 0, 3'b000); bStall = 0; bFlush = 0;
    rst = 1'b1;

    cyc();
    expA("reset_a", 6'h00, 0, 3'b000);
    expB("reset_b", 6'h00, 0, 3'b000, 16'd0);

    cyc(); rst = 1'b0;
    setA(1, 1, 0, 3, 1, 2, 2'b11);   expA("alu_issue", 6'h00, 0, 3'b000);
    cyc(); setA(1, 1, 0, 7, 3, 0, 2'b11);   expA("fwd_ex_mem", 6'h01, 0, 3'b001);
    cyc(); setA(1, 1, 0, 5, 3, 9, 2'b11);   expA("fwd_mem_wb", 6'h02, 0, 3'b011);
    cyc(); setA(1, 1, 0, 5, 1, 5, 2'b11);   expA("fwd_src1", 6'h04, 0, 3'b011);
    cyc(); setA(1, 1, 0, 0, 3, 5, 2'b11);   expA("double_hazard", 6'h04, 0, 3'b011);
    cyc(); setA(1, 0, 0, 0, 0, 5, 2'b11);   expA("reg_zero", 6'h08, 0, 3'b010);
    cyc(); setA(1, 1, 1, 4, 0, 0, 2'b00);   expA("lw_issue", 6'h00, 0, 3'b000);
    cyc(); setA(1, 1, 0, 6, 4, 4, 2'b01);   expA("load_use_stall", 6'h00, 1, 3'b001);
    cyc();                                  expA("load_use_fwd", 6'h02, 0, 3'b010);
    cyc(); setA(1, 1, 1, 9, 0, 6, 2'b10);   expA("used_gating", 6'h04, 0, 3'b001);
    cyc(); setA(0, 1, 0, 2, 9, 0, 2'b01);   expA("invalid_gate", 6'h00, 0, 3'b011);
    cyc(); setA(1, 1, 0, 10, 9, 0, 2'b01); aFlush = 1; aStall = 1;
    expA("flush_stall_pre", 6'h02, 0, 3'b010);
    cyc(); setA(1, 1, 1, 11, 9, 0, 2'b01); aFlush = 0; aStall = 0;
    expA("flush_stall_hold", 6'h02, 0, 3'b010);
    cyc(); setA(1, 1, 0, 12, 11, 0, 2'b01); aStall = 1;
    expA("ext_stall", 6'h00, 1, 3'b001);
    cyc(); aStall = 0;                       expA("ext_stall_release", 6'h00, 1, 3'b001);
    cyc();                                   expA("stall_fwd", 6'h02, 0, 3'b010);
    cyc(); setA(1, 1, 1, 13, 0, 0, 2'b00);  expA("lw2_issue", 6'h00, 0, 3'b001);
    cyc(); setA(1, 1, 0, 14, 13, 0, 2'b01); expA("pre_reset_stall", 6'h00, 1, 3'b011);

    // Reset between edges must clear everything before the next rising edge.
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    expA("async_reset_a", 6'h00, 0, 3'b000);
    expB("async_reset_b", 6'h00, 0, 3'b000, 16'd0);
    ->sampleEv;

    cyc(); rst = 1'b0;
    setA(0, 0, 0, 0, 0, 0, 2'b00);
    setB(1, 1, 1, 4, 0, 0, 0, 3'b000);  expB("b_lw", 6'h00, 0, 3'b000, 16'd0);
    cyc(); setB(1, 1, 0, 6, 1, 2, 4, 3'b111); expB("b_stall1", 6'h00, 1, 3'b001, 16'd0);
    cyc();                                     expB("b_stall2", 6'h00, 1, 3'b010, 16'd1);
    cyc();                                     expB("b_fwd3", 6'h30, 0, 3'b100, 16'd2);
    cyc(); setB(0, 0, 0, 0, 6, 0, 0, 3'b001); expB("b_drop", 6'h01, 0, 3'b001, 16'd2);

    cyc();
    @(negedge clk); #1;
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
